ram_arbiter: RTL and testbench

- Shares the computer's single-port program/data RAM between two requesters:
  - the CPU datapath (fetch, load, store);
  - a debug/loader port that writes hex images and inspects memory while the CPU runs.
- Fixed priority favours the CPU. A starvation counter guarantees the debug port a slot.
- A lock input lets either side hold the RAM for an uninterrupted burst.
- Sits between the CPU core, the loader and the RAM instance inside the top-level computer.

---
 rtl/ram_arbiter.sv | 102 ++++++++++
 tb/tb_ram_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single-port program/data RAM.
// CPU has fixed priority; a starvation counter forces debug requests through.
module ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic                  cpu_lock,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic                  dbg_lock,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_CPU,
        SRC_DBG
    } src_t;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    src_t       owner;
    src_t       rd_tag;
    logic [3:0] wait_cnt;
    logic       dbg_starved;

    assign dbg_starved = dbg_req && (wait_cnt == WAIT_MAX);

    // Grants are held off while reset is asserted.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (reset) begin
            priority case (1'b1)
                (owner == SRC_CPU) && cpu_req: cpu_gnt = 1'b1;
                (owner == SRC_DBG) && dbg_req: dbg_gnt = 1'b1;
                dbg_starved:                   dbg_gnt = 1'b1;
                cpu_req:                       cpu_gnt = 1'b1;
                dbg_req:                       dbg_gnt = 1'b1;
                default: ;
            endcase
        end
    end

    assign ram_we    = (cpu_gnt && cpu_we) || (dbg_gnt && dbg_we);
    assign ram_addr  = dbg_gnt ? dbg_addr : cpu_addr;
    assign ram_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner    <= SRC_NONE;
            rd_tag   <= SRC_NONE;
            wait_cnt <= 4'd0;
        end else begin
            if (cpu_gnt && cpu_lock) begin
                owner <= SRC_CPU;
            end else if (dbg_gnt && dbg_lock) begin
                owner <= SRC_DBG;
            end else begin
                owner <= SRC_NONE;
            end

            if (cpu_gnt && !cpu_we) begin
                rd_tag <= SRC_CPU;
            end else if (dbg_gnt && !dbg_we) begin
                rd_tag <= SRC_DBG;
            end else begin
                rd_tag <= SRC_NONE;
            end

            if (dbg_gnt || !dbg_req) begin
                wait_cnt <= 4'd0;
            end else if (wait_cnt < WAIT_MAX) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    assign cpu_rvalid = (rd_tag == SRC_CPU);
    assign dbg_rvalid = (rd_tag == SRC_DBG);
    assign cpu_rdata  = ram_rdata;
    assign dbg_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: vector table, directed corner cases and
// randomized traffic checked against a cycle-level reference model.
module tb_ram_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int MAX_WAIT = 4;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic          clk;
    logic          rst_n;
    logic          c_req, c_we, c_lock;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          d_req, d_we, d_lock;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    ram_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .cpu_req(c_req),
        .cpu_we(c_we),
        .cpu_lock(c_lock),
        .cpu_addr(c_addr),
        .cpu_wdata(c_wdata),
        .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata),
        .dbg_req(d_req),
        .dbg_we(d_we),
        .dbg_lock(d_lock),
        .dbg_addr(d_addr),
        .dbg_wdata(d_wdata),
        .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata),
        .ram_we(ram_we),
        .ram_addr(ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM
    logic [DW-1:0] ram_mem [16];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: who owns the RAM, how long debug has waited,
    // which read is due back and a shadow copy of memory.
    int            m_owner;
    int            m_wait;
    int            m_rv;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] shadow [16];
    logic          c_refused, d_refused;

    function automatic void model_gnt(output logic gc, output logic gd);
        gc = 1'b0;
        gd = 1'b0;
        if (!rst_n) return;
        if (m_owner == 1 && c_req) gc = 1'b1;
        else if (m_owner == 2 && d_req) gd = 1'b1;
        else if (d_req && m_wait == MAX_WAIT) gd = 1'b1;
        else if (c_req) gc = 1'b1;
        else if (d_req) gd = 1'b1;
    endfunction

    task automatic model_reset();
        m_owner = 0;
        m_wait = 0;
        m_rv = 0;
        c_refused = 1'b0;
        d_refused = 1'b0;
    endtask

    task automatic settle();
        logic gc, gd, we;
        #2;
        model_gnt(gc, gd);
        we = (gc && c_we) || (gd && d_we);
        chk("cpu_gnt", 32'(cpu_gnt), 32'(gc));
        chk("dbg_gnt", 32'(dbg_gnt), 32'(gd));
        chk("ram_we", 32'(ram_we), 32'(we));
        chk("ram_addr", 32'(ram_addr), 32'(gd ? d_addr : c_addr));
        if (we) chk("ram_wdata", 32'(ram_wdata), 32'(gd ? d_wdata : c_wdata));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_rv == 1));
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'(m_rv == 2));
        if (m_rv == 1) chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
        if (m_rv == 2) chk("dbg_rdata", 32'(dbg_rdata), 32'(m_rdata));
    endtask

    task automatic advance();
        logic gc, gd;
        model_gnt(gc, gd);
        @(posedge clk);
        if (rst_n) begin
            c_refused = c_req && !gc;
            d_refused = d_req && !gd;
            if (gc && !c_we) begin
                m_rv = 1;
                m_rdata = shadow[c_addr];
            end else if (gd && !d_we) begin
                m_rv = 2;
                m_rdata = shadow[d_addr];
            end else begin
                m_rv = 0;
            end
            if (gc && c_we) shadow[c_addr] = c_wdata;
            if (gd && d_we) shadow[d_addr] = d_wdata;
            m_owner = (gc && c_lock) ? 1 : (gd && d_lock) ? 2 : 0;
            if (gd || !d_req) m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait++;
        end
        @(negedge clk);
    endtask

    task automatic set_cpu(logic r, logic w, logic lk, logic [AW-1:0] a,
                           logic [DW-1:0] d);
        c_req = r; c_we = w; c_lock = lk; c_addr = a; c_wdata = d;
    endtask

    task automatic set_dbg(logic r, logic w, logic lk, logic [AW-1:0] a,
                           logic [DW-1:0] d);
        d_req = r; d_we = w; d_lock = lk; d_addr = a; d_wdata = d;
    endtask

    typedef struct {
        logic          cr, cw, cl;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic          dr, dw, dl;
        logic [AW-1:0] da;
        logic [DW-1:0] dd;
        logic          ecg, edg, ewe, ecv, edv;
        logic [DW-1:0] erd;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int n;
        int first_dbg;
        for (int i = 0; i < 16; i++) begin
            ram_mem[i] = '0;
            shadow[i] = '0;
        end
        m_rdata = '0;
        model_reset();
        rst_n = 1'b0;
        set_cpu(H, H, H, 4'h1, 8'h55);
        set_dbg(H, H, H, 4'h2, 8'h66);

        // Reset with both requests high
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("rst_ram_we", 32'(ram_we), 32'(0));
            chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'(0));
            chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'(0));
            advance();
        end
        set_cpu(L, L, L, 4'h0, 8'h00);
        set_dbg(L, L, L, 4'h0, 8'h00);
        rst_n = 1'b1;

        // cr cw cl ca cd | dr dw dl da dd | cg dg we cv dv rd
        tbl[0]  = '{H,H,L,4'h3,8'hA5, L,L,L,4'h0,8'h00, H,L,H,L,L,8'h00};
        tbl[1]  = '{H,L,L,4'h3,8'h00, L,L,L,4'h0,8'h00, H,L,L,L,L,8'h00};
        tbl[2]  = '{L,L,L,4'h3,8'h00, L,L,L,4'h0,8'h00, L,L,L,H,L,8'hA5};
        tbl[3]  = '{L,L,L,4'h3,8'h00, L,L,L,4'h0,8'h00, L,L,L,L,L,8'h00};
        tbl[4]  = '{H,L,L,4'h3,8'h00, H,L,L,4'h2,8'h00, H,L,L,L,L,8'h00};
        tbl[5]  = '{H,L,L,4'h3,8'h00, H,L,L,4'h2,8'h00, H,L,L,H,L,8'hA5};
        tbl[6]  = '{H,L,L,4'h3,8'h00, H,L,L,4'h2,8'h00, H,L,L,H,L,8'hA5};
        tbl[7]  = '{H,L,L,4'h3,8'h00, H,L,L,4'h2,8'h00, H,L,L,H,L,8'hA5};
        tbl[8]  = '{H,L,L,4'h3,8'h00, H,L,L,4'h2,8'h00, L,H,L,H,L,8'hA5};
        tbl[9]  = '{H,L,L,4'h3,8'h00, H,L,L,4'h2,8'h00, H,L,L,L,H,8'h00};
        tbl[10] = '{H,L,L,4'h3,8'h00, H,L,L,4'h2,8'h00, H,L,L,H,L,8'hA5};
        tbl[11] = '{H,L,L,4'h3,8'h00, H,L,L,4'h2,8'h00, H,L,L,H,L,8'hA5};
        tbl[12] = '{H,L,L,4'h3,8'h00, H,L,L,4'h2,8'h00, H,L,L,H,L,8'hA5};
        tbl[13] = '{H,L,L,4'h3,8'h00, H,L,L,4'h2,8'h00, L,H,L,H,L,8'hA5};
        tbl[14] = '{L,L,L,4'h3,8'h00, L,L,L,4'h0,8'h00, L,L,L,L,H,8'h00};

        for (int i = 0; i < 15; i++) begin
            set_cpu(tbl[i].cr, tbl[i].cw, tbl[i].cl, tbl[i].ca, tbl[i].cd);
            set_dbg(tbl[i].dr, tbl[i].dw, tbl[i].dl, tbl[i].da, tbl[i].dd);
            settle();
            chk($sformatf("vec%0d_cpu_gnt", i), 32'(cpu_gnt), 32'(tbl[i].ecg));
            chk($sformatf("vec%0d_dbg_gnt", i), 32'(dbg_gnt), 32'(tbl[i].edg));
            chk($sformatf("vec%0d_ram_we", i), 32'(ram_we), 32'(tbl[i].ewe));
            chk($sformatf("vec%0d_cpu_rv", i), 32'(cpu_rvalid), 32'(tbl[i].ecv));
            chk($sformatf("vec%0d_dbg_rv", i), 32'(dbg_rvalid), 32'(tbl[i].edv));
            if (tbl[i].ecv)
                chk($sformatf("vec%0d_cpu_rd", i), 32'(cpu_rdata), 32'(tbl[i].erd));
            if (tbl[i].edv)
                chk($sformatf("vec%0d_dbg_rd", i), 32'(dbg_rdata), 32'(tbl[i].erd));
            advance();
        end

        // Locked CPU holds off a starving debug request
        for (int i = 0; i < 8; i++) begin
            set_cpu(H, L, H, 4'h3, 8'h00);
            set_dbg(H, L, L, 4'h2, 8'h00);
            settle();
            chk($sformatf("lock%0d_dbg_gnt", i), 32'(dbg_gnt), 32'(0));
            chk($sformatf("lock%0d_cpu_gnt", i), 32'(cpu_gnt), 32'(1));
            advance();
        end
        set_cpu(L, L, L, 4'h3, 8'h00);
        settle();
        chk("unlock_dbg_gnt", 32'(dbg_gnt), 32'(1));
        advance();
        set_dbg(L, L, L, 4'h0, 8'h00);
        settle();
        advance();

        // Debug burst load under CPU contention
        for (int i = 0; i < 15; i++) begin
            set_cpu(H, L, L, 4'hF, 8'h00);
            set_dbg(H, H, H, 4'(i), 8'(8'h11 + i));
            n = 0;
            settle();
            while (!dbg_gnt && n < 20) begin
                advance();
                settle();
                n++;
            end
            chk($sformatf("burst%0d_refusals", i), 32'(n), 32'(i == 0 ? 4 : 0));
            advance();
        end
        set_dbg(L, L, L, 4'h0, 8'h00);
        settle();
        chk("after_burst_cpu_gnt", 32'(cpu_gnt), 32'(1));
        advance();
        set_cpu(L, L, L, 4'h0, 8'h00);
        settle();
        advance();
        for (int i = 0; i < 15; i++)
            chk($sformatf("burst_mem%0d", i), 32'(ram_mem[i]), 32'(8'h11 + i));

        // Reset lands between a debug read grant and its return
        set_dbg(H, L, L, 4'h5, 8'h00);
        settle();
        chk("pre_rst_dbg_gnt", 32'(dbg_gnt), 32'(1));
        #1;
        rst_n = 1'b0;
        model_reset();
        advance();
        set_dbg(L, L, L, 4'h0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("rst_mid_dbg_rvalid", 32'(dbg_rvalid), 32'(0));
            advance();
        end
        rst_n = 1'b1;
        settle();
        chk("post_rst_dbg_rvalid", 32'(dbg_rvalid), 32'(0));
        // Counter restarts from zero: debug forced through on the 5th cycle
        first_dbg = 0;
        for (int i = 1; i <= 6; i++) begin
            set_cpu(H, L, L, 4'h1, 8'h00);
            set_dbg(H, L, L, 4'h2, 8'h00);
            settle();
            if (dbg_gnt && first_dbg == 0) first_dbg = i;
            advance();
        end
        chk("post_rst_first_dbg", 32'(first_dbg), 32'(5));

        // Randomized traffic against the model
        model_reset();
        rst_n = 1'b0;
        set_cpu(L, L, L, 4'h0, 8'h00);
        set_dbg(L, L, L, 4'h0, 8'h00);
        settle();
        advance();
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (!c_refused)
                set_cpu(1'($urandom()), 1'($urandom()),
                        1'($urandom_range(0, 3) == 0),
                        4'($urandom()), 8'($urandom()));
            if (!d_refused)
                set_dbg(1'($urandom()), 1'($urandom()),
                        1'($urandom_range(0, 3) == 0),
                        4'($urandom()), 8'($urandom()));
            settle();
            advance();
        end
        set_cpu(L, L, L, 4'h0, 8'h00);
        set_dbg(L, L, L, 4'h0, 8'h00);
        settle();
        advance();
        for (int i = 0; i < 16; i++)
            chk($sformatf("final_mem%0d", i), 32'(ram_mem[i]), 32'(shadow[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
